// File: rtl/uart_tx_sched_if.sv
// Bundle of the two requester handshakes, the uart_tx drive lines and status flags.
// "slave" is the scheduler's view; "master" is the requester/transmitter side.
interface uart_tx_sched_if;
  logic       req0;
  logic [7:0] data0;
  logic       grant0;
  logic       req1;
  logic [7:0] data1;
  logic       grant1;
  logic [7:0] tx_in;
  logic       tx_send;
  logic       tx_done;
  logic       busy;
  logic       err;

  modport slave (
    input  req0, data0, req1, data1, tx_done,
    output grant0, grant1, tx_in, tx_send, busy, err
  );

  modport master (
    output req0, data0, req1, data1, tx_done,
    input  grant0, grant1, tx_in, tx_send, busy, err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin sharing of one uart_tx between two byte requesters, with an
// enforced inter-byte gap and a sticky watchdog on a missing tx_done.
module uart_tx_sched #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.slave   io_sched
);

  localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]     GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last;
  logic [7:0]    r_tx_in;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_gap_cnt;
  logic          r_err;

  logic          w_any_req;
  logic          w_pick;
  logic          w_expired;
  logic          w_busy;
  logic          w_send;
  logic          w_grant0;
  logic          w_grant1;

  // On a tie the requester not served last wins; r_last resets to 1 so 0 wins first.
  assign w_any_req = io_sched.req0 | io_sched.req1;
  assign w_pick    = (io_sched.req0 && io_sched.req1) ? ~r_last : io_sched.req1;
  assign w_expired = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_next = S_SEND;
      S_SEND: w_state_next = S_WAIT;
      S_WAIT: if (io_sched.tx_done || w_expired) w_state_next = S_GAP;
      S_GAP:  if (r_gap_cnt == 8'd0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_tx_in   <= 8'h00;
      r_to_cnt  <= '0;
      r_gap_cnt <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_tx_in <= w_pick ? io_sched.data1 : io_sched.data0;
            r_last  <= w_pick;
          end
        end
        S_SEND: r_to_cnt <= '0;
        S_WAIT: begin
          // A done arriving in the expiry cycle still counts as a clean completion.
          if (io_sched.tx_done) begin
            r_gap_cnt <= GAP_LOAD;
          end else if (w_expired) begin
            r_err     <= 1'b1;
            r_gap_cnt <= GAP_LOAD;
          end else begin
            r_to_cnt  <= r_to_cnt + TW'(1);
          end
        end
        S_GAP: if (r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_send   = (r_state == S_SEND);
    w_grant0 = w_send & ~r_last;
    w_grant1 = w_send &  r_last;
  end

  assign io_sched.busy    = w_busy;
  assign io_sched.tx_send = w_send;
  assign io_sched.grant0  = w_grant0;
  assign io_sched.grant1  = w_grant1;
  assign io_sched.tx_in   = r_tx_in;
  assign io_sched.err     = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: two instances (gap 2 and gap 5, both with a
// 16-cycle watchdog) driven by a tx_done stub; each grant is logged on one line.
module tb_uart_tx_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_sched_if ifa ();
  uart_tx_sched_if ifb ();

  uart_tx_sched #(.GAP_CYCLES(2), .TIMEOUT(16)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sched (ifa)
  );

  uart_tx_sched #(.GAP_CYCLES(5), .TIMEOUT(16)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sched (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for tx_send, then checks grant latency, winner and latched byte.
  task automatic expect_grant(input bit b, input int exp_n, input bit exp_sel,
                              input logic [7:0] exp_data, input string tag);
    int   n = 0;
    logic s;
    do begin
      tick();
      n++;
      s = b ? ifb.tx_send : ifa.tx_send;
    end while (!s && n < 12);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_sel"}, b ? {ifb.grant0, ifb.grant1} : {ifa.grant0, ifa.grant1},
        exp_sel ? 2'b01 : 2'b10);
    chk({tag, "_data"}, b ? ifb.tx_in : ifa.tx_in, exp_data);
    $display("%s: dut_%s grant%0d byte %02h after %0d cycles", tag, b ? "b" : "a",
             b ? ifb.grant1 : ifa.grant1, b ? ifb.tx_in : ifa.tx_in, n);
  endtask

  // Two WAIT cycles, a one-cycle tx_done, returning in the first GAP cycle.
  task automatic finish_byte_a();
    tick();
    tick();
    ifa.tx_done = 1'b1;
    tick();
    ifa.tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.req0 = 0; ifa.data0 = 8'h00; ifa.req1 = 0; ifa.data1 = 8'h00; ifa.tx_done = 0;
    ifb.req0 = 0; ifb.data0 = 8'h00; ifb.req1 = 0; ifb.data1 = 8'h00; ifb.tx_done = 0;

    // Reset state of both instances
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_a", {ifa.tx_in, ifa.tx_send, ifa.grant0, ifa.grant1, ifa.busy, ifa.err}, 0);
    chk("reset_b", {ifb.tx_in, ifb.tx_send, ifb.grant0, ifb.grant1, ifb.busy, ifb.err}, 0);

    // Single byte: grant one cycle after req, busy falls 3 cycles after tx_done
    rst_n = 1'b1;
    ifa.req0 = 1'b1; ifa.data0 = 8'h99;
    tick();
    chk("single_out", {ifa.grant0, ifa.grant1, ifa.tx_send, ifa.busy}, 4'b1011);
    chk("single_data", ifa.tx_in, 8'h99);
    ifa.req0 = 1'b0;
    tick();
    chk("single_pulse", {ifa.grant0, ifa.tx_send, ifa.busy}, 3'b001);
    finish_byte_a();
    chk("single_gap1", ifa.busy, 1'b1);
    tick();
    chk("single_gap2", ifa.busy, 1'b1);
    tick();
    chk("single_idle", {ifa.busy, ifa.err}, 2'b00);
    chk("single_hold", ifa.tx_in, 8'h99);

    // Tie from reset, then alternation with both requests held
    ifa.req0 = 1'b1; ifa.data0 = 8'hA5;
    ifa.req1 = 1'b1; ifa.data1 = 8'h3C;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_grant(1'b0, 1, 1'b0, 8'hA5, "tie1");
    finish_byte_a();
    expect_grant(1'b0, 3, 1'b1, 8'h3C, "alt2");
    finish_byte_a();
    expect_grant(1'b0, 3, 1'b0, 8'hA5, "alt3");
    finish_byte_a();
    expect_grant(1'b0, 3, 1'b1, 8'h3C, "alt4");
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    finish_byte_a();
    tick();
    tick();
    chk("alt_idle", ifa.busy, 1'b0);

    // Watchdog: err rises exactly 17 cycles after tx_send and survives later grants
    ifa.req1 = 1'b1; ifa.data1 = 8'h5A;
    expect_grant(1'b0, 1, 1'b1, 8'h5A, "wd_grant");
    ifa.req1 = 1'b0;
    repeat (16) tick();
    chk("wd_before", ifa.err, 1'b0);
    tick();
    chk("wd_set", {ifa.err, ifa.busy}, 2'b11);
    tick();
    tick();
    chk("wd_idle", ifa.busy, 1'b0);
    ifa.req0 = 1'b1; ifa.data0 = 8'hC3;
    expect_grant(1'b0, 1, 1'b0, 8'hC3, "wd_regrant");
    ifa.req0 = 1'b0;
    finish_byte_a();
    tick();
    tick();
    chk("wd_sticky", {ifa.err, ifa.busy}, 2'b10);

    // Collision: tx_done in the expiry cycle keeps err clear
    rst_n = 1'b0;
    tick();
    chk("reset_clears", {ifa.err, ifa.busy, ifa.tx_in}, 0);
    rst_n = 1'b1;
    ifa.req0 = 1'b1; ifa.data0 = 8'h0F;
    expect_grant(1'b0, 1, 1'b0, 8'h0F, "col_grant");
    ifa.req0 = 1'b0;
    repeat (16) tick();
    ifa.tx_done = 1'b1;
    tick();
    ifa.tx_done = 1'b0;
    chk("col_gap", {ifa.err, ifa.busy}, 2'b01);
    tick();
    tick();
    chk("col_idle", {ifa.err, ifa.busy}, 2'b00);

    // Reset mid-WAIT, then a stale tx_done must be ignored
    ifa.req1 = 1'b1; ifa.data1 = 8'h66;
    expect_grant(1'b0, 1, 1'b1, 8'h66, "rst_grant");
    ifa.req1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_wait", {ifa.tx_in, ifa.tx_send, ifa.grant0, ifa.grant1, ifa.busy, ifa.err}, 0);
    rst_n = 1'b1;
    ifa.tx_done = 1'b1;
    tick();
    ifa.tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_done", {ifa.tx_send, ifa.grant0, ifa.grant1, ifa.busy}, 0);
      tick();
    end

    // Gap of 5: with req1 held, IDLE at M+6 and the next grant at M+7
    ifb.req1 = 1'b1; ifb.data1 = 8'hE7;
    expect_grant(1'b1, 1, 1'b1, 8'hE7, "gap_first");
    tick();
    tick();
    ifb.tx_done = 1'b1;
    tick();
    ifb.tx_done = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("gap_hold", {ifb.grant1, ifb.tx_send, ifb.busy}, 3'b001);
      tick();
    end
    chk("gap_idle", {ifb.grant1, ifb.busy}, 2'b00);
    tick();
    chk("gap_regrant", {ifb.grant1, ifb.tx_send, ifb.busy}, 3'b111);
    chk("gap_data", ifb.tx_in, 8'hE7);
    $display("gap_regrant: dut_b grant1 byte %02h", ifb.tx_in);
    ifb.req1 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
